input_conditioner: RTL
======================

// Module: input_conditioner
// PURPOSE
//  Parametrised successor to the fixed 6-button/16-switch debouncer used on the Nexys4 top level.
//  - Synchronises and debounces NUM_BTN pushbuttons and NUM_SW switches, each with a per-channel
//    polarity inversion mask.
//  - Adds one-cycle press/release event pulses and sticky, software-clearable press flags.
//  - Drives a maskable interrupt to the KCPSM6 through the I/O interface block.
// PARAMETERS
//  NUM_BTN     6         number of pushbutton channels (1..16)
//  NUM_SW      16        number of switch channels (1..32)
//  DB_CYCLES   1000000   stable clk cycles required before a debounced output changes (10 ms @ 100 MHz)
//  SIM_CYCLES  4         stable-cycle count used instead of DB_CYCLES when SIMULATE=1
//  SIMULATE    0         1 selects SIM_CYCLES
//  BTN_INV     6'h01     per-button inversion; bit=1 means raw input active-low (btnCpuReset)
//  SW_INV      0         per-switch inversion mask
// PORTS
//  clk         in   1        system clock, 100 MHz
//  reset       in   1        asynchronous, active-low reset
//  pbtn_in     in   NUM_BTN  raw pushbuttons, asynchronous to clk
//  switch_in   in   NUM_SW   raw switches, asynchronous to clk
//  pbtn_db     out  NUM_BTN  debounced button level, logical polarity (1 = pressed)
//  swtch_db    out  NUM_SW   debounced switch level, logical polarity
//  btn_press   out  NUM_BTN  1-cycle pulse on debounced 0->1
//  btn_release out  NUM_BTN  1-cycle pulse on debounced 1->0
//  btn_sticky  out  NUM_BTN  sticky press flags
//  sticky_clr  in   NUM_BTN  clear mask for sticky flags, sampled every cycle (write-strobe qualified upstream)
//  irq_en      in   NUM_BTN  interrupt enable mask
//  irq         out  1        registered: |(btn_sticky & irq_en)
// BEHAVIOUR
//  - Reset: all outputs, synchronisers, counters and sticky flags are 0 while reset is low.
//    The debounced state resets to logical 0, so an idle active-low input yields no event after reset.
//  - Input path:
//    - 2-FF synchroniser per channel on the raw input.
//    - Inversion (XOR with INV mask) is applied after the synchroniser.
//  - Debounce counter, per channel, width $clog2(N+1) with N = SIMULATE ? SIM_CYCLES : DB_CYCLES:
//    - sync == db: counter cleared to 0.
//    - sync != db and counter < N-1: counter increments.
//    - sync != db and counter == N-1: db toggles and counter clears.
//    - Result: db changes exactly N cycles after the synchronised input first differs and then
//      stays stable.
//    - Any glitch back to db before N restarts the count from 0.
//  - Latency: raw edge -> pbtn_db change = 2 (sync) + N cycles.
//    - btn_press/btn_release assert in the same cycle pbtn_db changes; width exactly 1 cycle.
//    - Switches produce levels only, no events.
//  - Sticky flags:
//    - next = (sticky & ~sticky_clr) | btn_press.
//    - Set and clear in the same cycle on the same bit: set wins, flag stays 1.
//  - irq: registered, one cycle after the sticky/enable change.
//    - Stays high until all enabled flags are cleared.
//    - Disabling via irq_en deasserts irq next cycle without clearing flags.
//  - Asynchronous reset mid-count: counters abort, no event pulse is generated on the reset release cycle.
//  - Counter saturation cannot occur: the compare at N-1 bounds it.
//  - Widths: the NUM_BTN/NUM_SW masks are exact.
//    - No zero-extension on ports.
//    - Masks wider than the channel count are truncated at elaboration.
// STRUCTURE
//  - Shared include nexys4_defs.vh holds:
//    - CLK_HZ = 100_000_000
//    - the default DB_CYCLES
//    - button index constants BTN_RST=0, BTN_D=1, BTN_R=2, BTN_U=3, BTN_L=4, BTN_C=5
//  - Sub-module debounce_chan:
//    - one synchroniser, counter and db flop, with parameter COUNT and INV.
//    - Instantiated NUM_BTN+NUM_SW times via generate.
//  - Edge/sticky/irq logic sits in the top of input_conditioner.
// TESTING
//  - Bench configuration: SIMULATE=1, SIM_CYCLES=4, BTN_INV=6'h01.
//  1. Reset: hold reset low, raw inputs idle (pbtn_in=6'h01).
//     Release reset, run 20 cycles -> pbtn_db=0, no btn_press/btn_release pulse, irq=0.
//  2. Clean press: pbtn_in[3] 0->1 held.
//     -> pbtn_db[3] rises exactly 6 cycles after the input edge.
//     -> btn_press[3] high for 1 cycle.
//     -> btn_sticky[3]=1; with irq_en=6'h08, irq=1 one cycle later.
//  3. Bounce: pbtn_in[1] toggles 1,0,1,0 with 2-cycle periods, then settles 1.
//     -> exactly one btn_press[1], occurring 6 cycles after the last edge.
//  4. Clear collision: in the same cycle, btn_press[3] fires again and sticky_clr=6'h08.
//     -> btn_sticky[3] stays 1.
//     -> the next clear with no press gives btn_sticky[3]=0 and irq=0 one cycle later.
//  5. Active-low channel: pbtn_in[0] 1->0.
//     -> pbtn_db[0]=1 after 6 cycles, btn_press[0] pulse.
//     -> return to 1 gives a btn_release[0] pulse.
//  6. Reset mid-count: switch_in[7] changes.
//     Assert reset at cycle 3 of the count, release after 2 cycles.
//     -> swtch_db[7]=0 during reset, no event.
//     -> swtch_db[7]=1 is reached a full 6 cycles after reset release.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared board constants and helpers for the Nexys4 input conditioner.
// Holds the clock rate, default debounce length and button index map.
package input_conditioner_pkg;

    localparam int CLK_HZ        = 100_000_000;
    localparam int DB_CYCLES_DEF = 1_000_000;

    localparam int BTN_RST = 0;
    localparam int BTN_D   = 1;
    localparam int BTN_R   = 2;
    localparam int BTN_U   = 3;
    localparam int BTN_L   = 4;
    localparam int BTN_C   = 5;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_chan.sv
// One conditioned input: 2-FF synchroniser, polarity fix-up and stable-count debouncer.
// toggle is high in the cycle before db flips, so the parent can register edge pulses in step with db.
module debounce_chan
    import input_conditioner_pkg::*;
#(
    parameter int   COUNT = 4,
    parameter logic INV   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic toggle
);

    localparam int                CNT_W = cnt_width(COUNT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(COUNT - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             sync_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             toggle_s;
    logic             db_r;

    assign sync_s = sync2_r ^ INV;

    // Counter next-state: restart on any agreement, flip db on the COUNT-th disagreeing cycle.
    always_comb begin
        cnt_nxt_s = {CNT_W{1'b0}};
        toggle_s  = 1'b0;
        if (sync_s == db_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == LAST) begin
            toggle_s  = 1'b1;
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Synchroniser, counter and debounced level registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            db_r    <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_nxt_s;
            db_r    <= db_r ^ toggle_s;
        end
    end

    assign db     = db_r;
    assign toggle = toggle_s;

endmodule

// File: rtl/input_conditioner.sv
// Debounces pushbuttons and switches, generates button press/release pulses,
// sticky press flags and a maskable interrupt for the KCPSM6 I/O block.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int          NUM_BTN    = 6,
    parameter int          NUM_SW     = 16,
    parameter int          DB_CYCLES  = DB_CYCLES_DEF,
    parameter int          SIM_CYCLES = 4,
    parameter int          SIMULATE   = 0,
    parameter logic [15:0] BTN_INV    = 16'h0001,
    parameter logic [31:0] SW_INV     = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] pbtn_in,
    input  logic [NUM_SW-1:0]  switch_in,
    output logic [NUM_BTN-1:0] pbtn_db,
    output logic [NUM_SW-1:0]  swtch_db,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_sticky,
    input  logic [NUM_BTN-1:0] sticky_clr,
    input  logic [NUM_BTN-1:0] irq_en,
    output logic               irq
);

    localparam int N = (SIMULATE != 0) ? SIM_CYCLES : DB_CYCLES;

    logic [NUM_BTN-1:0] btn_db_s;
    logic [NUM_BTN-1:0] btn_toggle_s;
    logic [NUM_SW-1:0]  sw_toggle_unused_s;
    logic [NUM_BTN-1:0] press_r;
    logic [NUM_BTN-1:0] release_r;
    logic [NUM_BTN-1:0] sticky_r;
    logic               irq_r;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_chan #(
            .COUNT (N),
            .INV   (BTN_INV[i])
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .raw    (pbtn_in[i]),
            .db     (btn_db_s[i]),
            .toggle (btn_toggle_s[i])
        );
    end

    // Switches are levels only; their toggle strobes are deliberately dropped.
    for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
        debounce_chan #(
            .COUNT (N),
            .INV   (SW_INV[j])
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .raw    (switch_in[j]),
            .db     (swtch_db[j]),
            .toggle (sw_toggle_unused_s[j])
        );
    end

    // Edge pulses land with the db flip; sticky set beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_r   <= {NUM_BTN{1'b0}};
            release_r <= {NUM_BTN{1'b0}};
            sticky_r  <= {NUM_BTN{1'b0}};
            irq_r     <= 1'b0;
        end else begin
            press_r   <= btn_toggle_s & ~btn_db_s;
            release_r <= btn_toggle_s & btn_db_s;
            sticky_r  <= (sticky_r & ~sticky_clr) | press_r;
            irq_r     <= |(sticky_r & irq_en);
        end
    end

    assign pbtn_db     = btn_db_s;
    assign btn_press   = press_r;
    assign btn_release = release_r;
    assign btn_sticky  = sticky_r;
    assign irq         = irq_r;

endmodule
